// File: rtl/midterm_1bit.sv
// midterm_1bit: single-bit ALU slice with registered result/carry-out and an
// internal carry flag so ADC/SBC can chain across successive cycles.
module midterm_1bit (
   input  logic       clk,
   input  logic       rst,
   input  logic       op1,
   input  logic       op2,
   input  logic [2:0] opsel,
   input  logic       mode,
   output logic       result_final,
   output logic       Cout_final
);

   localparam int unsigned SUM_W = 2;

   // Arithmetic-mode operation codes
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_INC  = 3'b010;
   localparam logic [2:0] OP_DEC  = 3'b011;
   localparam logic [2:0] OP_PASS = 3'b100;
   localparam logic [2:0] OP_ADC  = 3'b101;
   localparam logic [2:0] OP_SBC  = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;

   // Logic-mode operation codes
   localparam logic [2:0] LG_AND  = 3'b000;
   localparam logic [2:0] LG_OR   = 3'b001;
   localparam logic [2:0] LG_XOR  = 3'b010;
   localparam logic [2:0] LG_NOT1 = 3'b011;
   localparam logic [2:0] LG_NAND = 3'b100;
   localparam logic [2:0] LG_NOR  = 3'b101;
   localparam logic [2:0] LG_XNOR = 3'b110;
   localparam logic [2:0] LG_NOT2 = 3'b111;

   logic              cflag;
   logic              add_b_c;
   logic              add_ci_c;
   logic              arith_pass_c;
   logic              arith_zero_c;
   logic [SUM_W-1:0]  sum_c;
   logic              arith_res_c;
   logic              arith_cout_c;
   logic              logic_res_c;
   logic              res_c;
   logic              cout_c;
   logic              cflag_we_c;

   // Every arithmetic op is one adder pass; pick its B operand and carry-in
   always_comb begin
      add_b_c      = 1'b0;
      add_ci_c     = 1'b0;
      arith_pass_c = 1'b0;
      arith_zero_c = 1'b0;
      case (opsel)
         OP_ADD: begin
            add_b_c  = op2;
            add_ci_c = 1'b0;
         end
         OP_SUB: begin
            add_b_c  = ~op2;
            add_ci_c = 1'b1;
         end
         OP_INC: begin
            add_b_c  = 1'b0;
            add_ci_c = 1'b1;
         end
         OP_DEC: begin
            // adding all-ones; carry-out low signals a borrow
            add_b_c  = 1'b1;
            add_ci_c = 1'b0;
         end
         OP_PASS: begin
            arith_pass_c = 1'b1;
         end
         OP_ADC: begin
            add_b_c  = op2;
            add_ci_c = cflag;
         end
         OP_SBC: begin
            add_b_c  = ~op2;
            add_ci_c = cflag;
         end
         OP_RSVD: begin
            arith_zero_c = 1'b1;
         end
         default: begin
            arith_zero_c = 1'b1;
         end
      endcase
   end

   // Shared 1-bit adder producing {cout,res}
   always_comb begin
      sum_c = SUM_W'(op1) + SUM_W'(add_b_c) + SUM_W'(add_ci_c);
   end

   // Arithmetic result, with PASS and reserved overriding the adder
   always_comb begin
      arith_res_c  = sum_c[0];
      arith_cout_c = sum_c[1];
      if (arith_pass_c) begin
         arith_res_c  = op1;
         arith_cout_c = 1'b0;
      end else if (arith_zero_c) begin
         arith_res_c  = 1'b0;
         arith_cout_c = 1'b0;
      end
   end

   // Bitwise logic unit
   always_comb begin
      logic_res_c = 1'b0;
      case (opsel)
         LG_AND:  logic_res_c = op1 & op2;
         LG_OR:   logic_res_c = op1 | op2;
         LG_XOR:  logic_res_c = op1 ^ op2;
         LG_NOT1: logic_res_c = ~op1;
         LG_NAND: logic_res_c = ~(op1 & op2);
         LG_NOR:  logic_res_c = ~(op1 | op2);
         LG_XNOR: logic_res_c = ~(op1 ^ op2);
         LG_NOT2: logic_res_c = ~op2;
         default: logic_res_c = 1'b0;
      endcase
   end

   // Mode select and carry-flag write enable (logic ops and reserved hold it)
   always_comb begin
      res_c      = arith_res_c;
      cout_c     = arith_cout_c;
      cflag_we_c = 1'b0;
      if (mode) begin
         res_c  = logic_res_c;
         cout_c = 1'b0;
      end else begin
         cflag_we_c = (opsel != OP_RSVD);
      end
   end

   // Output and carry-flag registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         result_final <= 1'b0;
         Cout_final   <= 1'b0;
         cflag        <= 1'b0;
      end else begin
         result_final <= res_c;
         Cout_final   <= cout_c;
         if (cflag_we_c) begin
            cflag <= cout_c;
         end
      end
   end

endmodule

// File: tb/tb_midterm_1bit.sv
// Scoreboard bench for midterm_1bit: the driver pushes expected outputs,
// a monitor pops and compares one entry after every rising edge.
module tb_midterm_1bit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       op1 = 1'b0;
   logic       op2 = 1'b0;
   logic [2:0] opsel = 3'b000;
   logic       mode = 1'b0;
   logic       result_final;
   logic       Cout_final;

   typedef struct packed {
      logic res;
      logic cout;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];

   int    n_checks = 0;
   int    n_fail   = 0;
   logic  m_cflag  = 1'b0;

   midterm_1bit dut (
      .clk          (clk),
      .rst          (rst),
      .op1          (op1),
      .op2          (op2),
      .opsel        (opsel),
      .mode         (mode),
      .result_final (result_final),
      .Cout_final   (Cout_final)
   );

   always #5 clk = ~clk;

   // Reference model: integer arithmetic straight from the operation table
   task automatic model(input logic r, input logic a, input logic b,
                        input logic [2:0] s, input logic m,
                        output logic er, output logic ec);
      int sum;
      int ai;
      int bi;
      int ci;
      ai = int'(a);
      bi = int'(b);
      ci = int'(m_cflag);
      if (r) begin
         er = 1'b0; ec = 1'b0; m_cflag = 1'b0;
      end else if (m) begin
         ec = 1'b0;
         case (s)
            3'd0: er = a & b;
            3'd1: er = a | b;
            3'd2: er = a ^ b;
            3'd3: er = !a;
            3'd4: er = !(a & b);
            3'd5: er = !(a | b);
            3'd6: er = (a == b);
            default: er = !b;
         endcase
      end else begin
         case (s)
            3'd0: sum = ai + bi;
            3'd1: sum = ai + (1 - bi) + 1;
            3'd2: sum = ai + 1;
            3'd3: sum = ai + 1;
            3'd4: sum = ai;
            3'd5: sum = ai + bi + ci;
            3'd6: sum = ai + (1 - bi) + ci;
            default: sum = 0;
         endcase
         er = (sum % 2) == 1;
         ec = (sum / 2) == 1;
         if (s != 3'd7) m_cflag = ec;
      end
   endtask

   // Drive one cycle; push the hand-computed expectation
   task automatic step(input logic r, input logic a, input logic b,
                       input logic [2:0] s, input logic m,
                       input logic x_res, input logic x_cout, input string nm);
      logic er, ec;
      @(negedge clk);
      rst = r; op1 = a; op2 = b; opsel = s; mode = m;
      model(r, a, b, s, m, er, ec);
      exp_q.push_back('{res: x_res, cout: x_cout});
      name_q.push_back(nm);
   endtask

   // Drive one cycle; push the model's expectation
   task automatic rstep(input logic r, input logic a, input logic b,
                        input logic [2:0] s, input logic m);
      logic er, ec;
      @(negedge clk);
      rst = r; op1 = a; op2 = b; opsel = s; mode = m;
      model(r, a, b, s, m, er, ec);
      exp_q.push_back('{res: er, cout: ec});
      name_q.push_back($sformatf("rand r=%0b m=%0b s=%0d a=%0b b=%0b", r, m, s, a, b));
   endtask

   // Monitor: outputs are valid one edge after each driven cycle
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t  e;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_checks++;
         if (result_final !== e.res || Cout_final !== e.cout) begin
            n_fail++;
            $display("FAIL %s: got res=%b cout=%b, expected res=%b cout=%b",
                     nm, result_final, Cout_final, e.res, e.cout);
         end
      end
   end

   initial begin
      logic [2:0] lsel;
      int         wait_cyc;

      // reset, then ADC 0+0 shows the carry flag was cleared
      step(1, 1, 1, 3'b101, 0, 0, 0, "reset1");
      step(1, 0, 1, 3'b000, 1, 0, 0, "reset2");
      step(0, 0, 0, 3'b101, 0, 0, 0, "adc_after_reset");

      // arithmetic sweep, op1=op2=1
      step(0, 1, 1, 3'b000, 0, 0, 1, "add_11");
      step(0, 1, 1, 3'b001, 0, 0, 1, "sub_11");
      step(0, 1, 1, 3'b010, 0, 0, 1, "inc_1");
      step(0, 1, 1, 3'b011, 0, 0, 1, "dec_1");
      step(0, 1, 1, 3'b100, 0, 1, 0, "pass_1");
      step(0, 1, 1, 3'b000, 0, 0, 1, "add_set_cflag");
      step(0, 1, 1, 3'b101, 0, 1, 1, "adc_11_c1");
      step(0, 1, 1, 3'b110, 0, 0, 1, "sbc_11_c1");

      // borrow cases
      step(0, 0, 1, 3'b001, 0, 1, 0, "sub_01_borrow");
      step(0, 0, 0, 3'b011, 0, 1, 0, "dec_0_borrow");
      step(0, 0, 0, 3'b010, 0, 1, 0, "inc_0");

      // logic sweep, op1=op2=1
      for (int i = 0; i < 8; i++) begin
         logic [7:0] lexp;
         lexp = 8'b0100_0011;
         lsel = 3'(i);
         step(0, 1, 1, lsel, 1, lexp[i], 0, $sformatf("logic_op%0d", i));
      end

      // carry chaining through a logic op
      step(0, 1, 1, 3'b000, 0, 0, 1, "chain_add");
      step(0, 1, 1, 3'b000, 1, 1, 0, "chain_and_hold");
      step(0, 0, 0, 3'b101, 0, 1, 0, "chain_adc");
      step(0, 0, 0, 3'b101, 0, 0, 0, "chain_adc_clear");

      // reserved op outputs zero and holds the carry flag
      step(0, 1, 1, 3'b000, 0, 0, 1, "rsvd_set");
      step(0, 1, 1, 3'b111, 0, 0, 0, "rsvd_zero");
      step(0, 0, 0, 3'b101, 0, 1, 0, "rsvd_hold_adc");

      // single-edge reset clears the carry flag
      step(0, 1, 1, 3'b000, 0, 0, 1, "pre_rst_add");
      step(1, 1, 1, 3'b000, 0, 0, 0, "single_rst");
      step(0, 0, 0, 3'b101, 0, 0, 0, "post_rst_adc");

      // random sequence with occasional mid-sequence reset
      for (int i = 0; i < 300; i++) begin
         rstep(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
               3'($urandom), 1'($urandom));
      end

      // let the monitor drain the scoreboard
      @(negedge clk);
      rst = 1'b0;
      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
